// File: rtl/theta_iteration_seq.sv
// theta_iteration_seq
// Paces point-index requests into the thetaCos datapath, waits for each result
// and republishes it tagged with index, column, frame and sweep direction.
// The index walks the scan as a sawtooth or as a triangle. Column and frame
// are counters kept in lock-step with the index, so no divider is needed.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | no request outstanding; waits for enable_i & tick_i
// ISSUE    | one-cycle request strobe carrying the current index
// WAIT     | waits for the result strobe or the timeout terminal count
// ADVANCE  | publishes the captured point, then steps or restarts index

module theta_iteration_seq #(
    parameter int FRAME_COLUMNS_P = 360,
    parameter int FRAME_NUMBER_P  = 5,
    parameter int SWEEP_MODE_P    = 1,
    parameter int TIMEOUT_P       = 64
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        enable_i,
    input  logic        restart_i,
    input  logic        tick_i,
    output logic        theta_iteration_valid_o,
    output logic [11:0] theta_iteration_o,
    input  logic        thetaCos_valid_i,
    input  logic [33:0] thetaCos_i,
    output logic        point_valid_o,
    output logic [33:0] point_o,
    output logic [11:0] point_index_o,
    output logic [11:0] column_o,
    output logic [11:0] frame_o,
    output logic        dir_o,
    output logic        sweep_done_o,
    output logic        busy_o,
    output logic        overrun_o,
    output logic        timeout_o
);

    localparam int          TOTAL_POINTS_P = FRAME_COLUMNS_P * FRAME_NUMBER_P;
    localparam logic [11:0] LAST_IDX       = 12'(TOTAL_POINTS_P - 1);
    localparam logic [11:0] LAST_COL       = 12'(FRAME_COLUMNS_P - 1);
    localparam int          TW             = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;
    localparam logic [TW-1:0] TO_LAST      = TW'(TIMEOUT_P - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_ADVANCE = 2'd3;

    logic [1:0]    state;
    logic [11:0]   index;
    logic [11:0]   col;
    logic [11:0]   frame;
    logic          dir;
    logic [TW-1:0] to_cnt;
    logic          captured;
    logic          restart_pend;

    logic [11:0]   nxt_index;
    logic [11:0]   nxt_col;
    logic [11:0]   nxt_frame;
    logic          nxt_dir;
    logic          wrap;
    logic          go_up;
    logic          go_down;

    assign theta_iteration_valid_o = (state == ST_ISSUE);
    assign theta_iteration_o       = (state == ST_ISSUE) ? index : 12'd0;
    assign busy_o                  = (state != ST_IDLE);
    assign dir_o                   = dir;

    // Next position of the scan; sweep completion is flagged on the step
    // that leaves the last point of a turn.
    always_comb begin
        nxt_index = index;
        nxt_col   = col;
        nxt_frame = frame;
        nxt_dir   = dir;
        wrap      = 1'b0;
        go_up     = 1'b0;
        go_down   = 1'b0;
        if (SWEEP_MODE_P == 0) begin
            if (index == LAST_IDX) begin
                nxt_index = 12'd0;
                nxt_col   = 12'd0;
                nxt_frame = 12'd0;
                wrap      = 1'b1;
            end else begin
                go_up = 1'b1;
            end
        end else if (!dir) begin
            if (index == LAST_IDX) begin
                nxt_dir = 1'b1;
                go_down = 1'b1;
            end else begin
                go_up = 1'b1;
            end
        end else begin
            if (index == 12'd0) begin
                nxt_dir = 1'b0;
                go_up   = 1'b1;
                wrap    = 1'b1;
            end else begin
                go_down = 1'b1;
            end
        end
        if (go_up) begin
            nxt_index = index + 12'd1;
            if (col == LAST_COL) begin
                nxt_col   = 12'd0;
                nxt_frame = frame + 12'd1;
            end else begin
                nxt_col = col + 12'd1;
            end
        end
        if (go_down) begin
            nxt_index = index - 12'd1;
            if (col == 12'd0) begin
                nxt_col   = LAST_COL;
                nxt_frame = frame - 12'd1;
            end else begin
                nxt_col = col - 12'd1;
            end
        end
    end

    // Request/response sequencer; a restart arriving mid-transaction is held
    // until ADVANCE so the in-flight point is still published.
    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state         <= ST_IDLE;
            index         <= 12'd0;
            col           <= 12'd0;
            frame         <= 12'd0;
            dir           <= 1'b0;
            to_cnt        <= '0;
            captured      <= 1'b0;
            restart_pend  <= 1'b0;
            point_valid_o <= 1'b0;
            point_o       <= 34'd0;
            point_index_o <= 12'd0;
            column_o      <= 12'd0;
            frame_o       <= 12'd0;
            sweep_done_o  <= 1'b0;
            overrun_o     <= 1'b0;
            timeout_o     <= 1'b0;
        end else begin
            point_valid_o <= 1'b0;
            sweep_done_o  <= 1'b0;
            if (tick_i && (state != ST_IDLE)) begin
                overrun_o <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (restart_i) begin
                        index     <= 12'd0;
                        col       <= 12'd0;
                        frame     <= 12'd0;
                        dir       <= 1'b0;
                        overrun_o <= 1'b0;
                        timeout_o <= 1'b0;
                    end
                    if (enable_i && tick_i) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    to_cnt   <= '0;
                    captured <= 1'b0;
                    state    <= ST_WAIT;
                    if (restart_i) begin
                        restart_pend <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (restart_i) begin
                        restart_pend <= 1'b1;
                    end
                    if (thetaCos_valid_i) begin
                        captured      <= 1'b1;
                        point_o       <= thetaCos_i;
                        point_index_o <= index;
                        column_o      <= col;
                        frame_o       <= frame;
                        state         <= ST_ADVANCE;
                    end else if (to_cnt == TO_LAST) begin
                        timeout_o <= 1'b1;
                        state     <= ST_ADVANCE;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                end
                default: begin
                    point_valid_o <= captured;
                    state         <= ST_IDLE;
                    if (restart_i || restart_pend) begin
                        index        <= 12'd0;
                        col          <= 12'd0;
                        frame        <= 12'd0;
                        dir          <= 1'b0;
                        overrun_o    <= 1'b0;
                        timeout_o    <= 1'b0;
                        restart_pend <= 1'b0;
                    end else begin
                        index        <= nxt_index;
                        col          <= nxt_col;
                        frame        <= nxt_frame;
                        dir          <= nxt_dir;
                        sweep_done_o <= wrap;
                    end
                end
            endcase
        end
    end

endmodule
